// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester round-robin write-back arbiter staging one register-file write per cycle,
// with a forwarding/hazard query port and a saturating conflict counter.
module rf_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int CW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            r0_vld,
   input  logic [AW-1:0]   r0_addr,
   input  logic [XLEN-1:0] r0_data,
   output logic            r0_rdy,
   input  logic            r1_vld,
   input  logic [AW-1:0]   r1_addr,
   input  logic [XLEN-1:0] r1_data,
   output logic            r1_rdy,
   output logic            RegWrite,
   output logic [AW-1:0]   a3,
   output logic [XLEN-1:0] wd3,
   input  logic [AW-1:0]   q_addr,
   output logic            q_hit,
   output logic [XLEN-1:0] q_data,
   output logic [CW-1:0]   conflict_cnt
);
   logic            prio;
   logic            both;
   logic            hs;
   logic [AW-1:0]   a_sel;
   logic [XLEN-1:0] d_sel;
   // Grants are masked by rst_n so no handshake can complete while reset is held.
   always_comb begin
      both   = r0_vld & r1_vld;
      r0_rdy = rst_n & r0_vld & (~r1_vld | ~prio);
      r1_rdy = rst_n & r1_vld & (~r0_vld | prio);
      hs     = r0_rdy | r1_rdy;
      a_sel  = r1_rdy ? r1_addr : r0_addr;
      d_sel  = r1_rdy ? r1_data : r0_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite     <= 1'b0;
         a3           <= '0;
         wd3          <= '0;
         prio         <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         RegWrite <= hs && (a_sel != '0);
         if (hs) begin
            a3  <= a_sel;
            wd3 <= d_sel;
         end
         // On a conflict the winner is prio, so the loser (next priority) is ~prio.
         if (both) prio <= ~prio;
         if (both && (conflict_cnt != {CW{1'b1}})) conflict_cnt <= conflict_cnt + 1'b1;
      end
   end
   assign q_hit  = RegWrite && (a3 == q_addr) && (q_addr != '0);
   assign q_data = wd3;
endmodule
